// File: rtl/date_set_ctrl.sv
// Day-of-month (1..30) setting controller: captures the counter value, steps it with buttons, loads it back.
// Optional hold-to-repeat stepping is enabled by defining DATE_SET_AUTOREPEAT_EN.
module date_set_ctrl #(
    parameter int TIMEOUT      = 1000,
    parameter int BLINK_DIV    = 250,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       set_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic [4:0] databus_in,
    output logic       rd_en,
    output logic       load_out,
    output logic [4:0] data_out,
    output logic       editing,
    output logic       blink
);

    localparam int IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_EDIT,
        S_COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          edit_val_q, edit_val_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;

    // Bit order: 0 = set, 1 = up, 2 = down
    logic [2:0] btn_raw;
    logic [2:0] btn_lvl;
    logic [2:0] press_p;
    logic       rep_up, rep_dn;
    logic       step_up, step_dn;

    assign btn_raw = {down_btn, up_btn, set_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic sync1_q, sync2_q, prev_q;
            always_ff @(posedge clk or posedge clear) begin
                if (clear) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    prev_q  <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    prev_q  <= sync2_q;
                end
            end
            assign btn_lvl[gi] = sync2_q;
            assign press_p[gi] = sync2_q & ~prev_q;
        end
    endgenerate

`ifdef DATE_SET_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fire;

    // After the first repeat the counter is rewound so later repeats come every REPEAT_RATE cycles.
    always_comb begin
        rep_cnt_d = '0;
        rep_fire  = 1'b0;
        if (state_q == S_EDIT && (btn_lvl[1] ^ btn_lvl[2])) begin
            if (rep_cnt_q == REP_W'(REPEAT_DELAY)) begin
                rep_fire  = 1'b1;
                rep_cnt_d = REP_W'(REPEAT_DELAY - REPEAT_RATE + 1);
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) rep_cnt_q <= '0;
        else       rep_cnt_q <= rep_cnt_d;
    end

    assign rep_up = rep_fire & btn_lvl[1];
    assign rep_dn = rep_fire & btn_lvl[2];
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;

    // Repeat timing parameters have no effect in this build.
    if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_repeat_cfg_unused
    end
`endif

    assign step_up = press_p[1] | rep_up;
    assign step_dn = press_p[2] | rep_dn;

    always_comb begin
        state_d     = state_q;
        edit_val_d  = edit_val_q;
        idle_cnt_d  = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (press_p[0]) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_EDIT;
                if (databus_in == 5'd0 || databus_in > 5'd30) edit_val_d = 5'd1;
                else                                          edit_val_d = databus_in;
            end
            S_EDIT: begin
                if (press_p[0]) begin
                    state_d = S_COMMIT;
                end else begin
                    if (!(step_up || step_dn)) begin
                        if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) state_d = S_IDLE;
                        else                                    idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                    if (step_up && !step_dn)
                        edit_val_d = (edit_val_q == 5'd30) ? 5'd1 : edit_val_q + 5'd1;
                    else if (step_dn && !step_up)
                        edit_val_d = (edit_val_q == 5'd1) ? 5'd30 : edit_val_q - 5'd1;
                end
                if (state_d == S_EDIT) begin
                    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                        blink_d = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                        blink_d     = blink_q;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            edit_val_q  <= 5'd1;
            idle_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_val_q  <= edit_val_d;
            idle_cnt_q  <= idle_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign rd_en    = (state_q == S_CAPTURE);
    assign load_out = (state_q == S_COMMIT);
    assign editing  = (state_q == S_CAPTURE) || (state_q == S_EDIT);
    assign data_out = edit_val_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed bench for date_set_ctrl: table of capture/step/commit vectors plus hand-written corner sequences.
module tb_date_set_ctrl;

    localparam int TO = 40;
    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic       set_btn, up_btn, down_btn;
    logic [4:0] databus_in;
    logic       rd_en, load_out, editing, blink;
    logic [4:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    date_set_ctrl #(
        .TIMEOUT      (TO),
        .BLINK_DIV    (BD),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (4)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .set_btn    (set_btn),
        .up_btn     (up_btn),
        .down_btn   (down_btn),
        .databus_in (databus_in),
        .rd_en      (rd_en),
        .load_out   (load_out),
        .data_out   (data_out),
        .editing    (editing),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cap;
        int cap_exp;
        int ups;
        int downs;
        int exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw level held for one edge; returns once the resulting change is visible.
    task automatic press(input logic s, input logic u, input logic d);
        @(negedge clk);
        set_btn = s; up_btn = u; down_btn = d;
        @(negedge clk);
        set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
        cyc(2);
    endtask

    task automatic enter_edit(input int cap);
        databus_in = 5'(cap);
        press(1'b1, 1'b0, 1'b0);
        cyc(1);
    endtask

    initial begin
        int loads;

        vecs[0] = '{cap: 17, cap_exp: 17, ups: 3, downs: 0, exp: 20};
        vecs[1] = '{cap: 30, cap_exp: 30, ups: 1, downs: 0, exp: 1};
        vecs[2] = '{cap: 1,  cap_exp: 1,  ups: 0, downs: 2, exp: 29};
        vecs[3] = '{cap: 0,  cap_exp: 1,  ups: 0, downs: 0, exp: 1};
        vecs[4] = '{cap: 31, cap_exp: 1,  ups: 0, downs: 1, exp: 30};
        vecs[5] = '{cap: 29, cap_exp: 29, ups: 2, downs: 0, exp: 1};
        vecs[6] = '{cap: 15, cap_exp: 15, ups: 2, downs: 2, exp: 15};

        clear = 1'b1; set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0; databus_in = 5'd0;
        cyc(2);
        chk("reset rd_en", rd_en, 0);
        chk("reset load_out", load_out, 0);
        chk("reset data_out", data_out, 1);
        chk("reset editing", editing, 0);
        chk("reset blink", blink, 0);
        clear = 1'b0;
        cyc(1);

        press(1'b0, 1'b1, 1'b0);
        chk("idle up ignored editing", editing, 0);
        chk("idle up ignored data", data_out, 1);

        for (int i = 0; i < 7; i++) begin
            databus_in = 5'(vecs[i].cap);
            press(1'b1, 1'b0, 1'b0);
            chk($sformatf("v%0d capture rd_en", i), rd_en, 1);
            cyc(1);
            databus_in = 5'd7;
            chk($sformatf("v%0d edit rd_en", i), rd_en, 0);
            chk($sformatf("v%0d edit editing", i), editing, 1);
            chk($sformatf("v%0d captured", i), data_out, vecs[i].cap_exp);
            for (int u = 0; u < vecs[i].ups; u++) press(1'b0, 1'b1, 1'b0);
            for (int d = 0; d < vecs[i].downs; d++) press(1'b0, 1'b0, 1'b1);
            chk($sformatf("v%0d stepped", i), data_out, vecs[i].exp);
            press(1'b1, 1'b0, 1'b0);
            chk($sformatf("v%0d commit load", i), load_out, 1);
            chk($sformatf("v%0d commit data", i), data_out, vecs[i].exp);
            cyc(1);
            chk($sformatf("v%0d load one cycle", i), load_out, 0);
            chk($sformatf("v%0d back idle", i), editing, 0);
        end

        // Simultaneous up+down, then set+up together
        enter_edit(12);
        press(1'b0, 1'b1, 1'b1);
        chk("up+down unchanged", data_out, 12);
        press(1'b0, 1'b1, 1'b0);
        chk("up after both", data_out, 13);
        press(1'b1, 1'b1, 1'b0);
        chk("set+up load", load_out, 1);
        chk("set+up data", data_out, 13);
        cyc(1);
        chk("set+up idle", editing, 0);

        // Timeout with blink
        enter_edit(8);
        chk("timeout first edit blink", blink, 0);
        chk("timeout first edit editing", editing, 1);
        loads = 0;
        repeat (BD) begin
            @(negedge clk);
            if (load_out) loads++;
        end
        chk("blink toggled", blink, 1);
        repeat (TO - 1 - BD) begin
            @(negedge clk);
            if (load_out) loads++;
        end
        chk("last edit cycle editing", editing, 1);
        cyc(1);
        if (load_out) loads++;
        chk("timeout editing", editing, 0);
        chk("timeout blink", blink, 0);
        chk("timeout no load", loads, 0);
        chk("timeout rd_en", rd_en, 0);

        // Held up button
        enter_edit(5);
        @(negedge clk);
        up_btn = 1'b1;
        repeat (24) @(negedge clk);
        up_btn = 1'b0;
        cyc(4);
`ifdef DATE_SET_AUTOREPEAT_EN
        chk("hold up value", data_out, 10);
`else
        chk("hold up value", data_out, 6);
`endif
        press(1'b1, 1'b0, 1'b0);
        chk("hold commit load", load_out, 1);
        cyc(1);

        // Clear during EDIT, sampled with no clock edge
        enter_edit(20);
        press(1'b0, 1'b1, 1'b0);
        chk("pre-clear value", data_out, 21);
        #2 clear = 1'b1;
        #1;
        chk("clear edit editing", editing, 0);
        chk("clear edit data", data_out, 1);
        chk("clear edit blink", blink, 0);
        chk("clear edit rd_en", rd_en, 0);
        @(negedge clk);
        clear = 1'b0;

        // Clear during COMMIT
        enter_edit(9);
        press(1'b1, 1'b0, 1'b0);
        chk("pre-clear commit load", load_out, 1);
        #1 clear = 1'b1;
        #1;
        chk("clear commit load", load_out, 0);
        chk("clear commit data", data_out, 1);
        @(negedge clk);
        clear = 1'b0;
        cyc(2);
        chk("after clear commit load", load_out, 0);
        chk("after clear commit editing", editing, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
